// File: rtl/idli_sqi_ctrl.sv
// Lockstep controller for the LO/HI SQI memories: quad-mode entry after reset,
// then command/address/dummy/data streams on a shared CS and SCK.
package idli_pkg;
    localparam int SQI_NUM = 2;
    typedef logic [3:0] sqi_data_t;
endpackage

module idli_sqi_ctrl
    import idli_pkg::*;
(
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_req,
    input  logic                               i_wr,
    input  logic [15:0]                        i_addr,
    input  logic                               i_stop,
    output logic                               o_idle,
    output logic                               o_rd_vld,
    output logic [SQI_NUM*$bits(sqi_data_t)-1:0] o_rd_data,
    output logic                               o_wr_rdy,
    input  logic [SQI_NUM*$bits(sqi_data_t)-1:0] i_wr_data,
    output logic                               o_sqi_cs_n,
    output logic                               o_sqi_sck_en,
    output logic [SQI_NUM*$bits(sqi_data_t)-1:0] o_sqi_sio_out,
    output logic                               o_sqi_sio_oe,
    input  logic [SQI_NUM*$bits(sqi_data_t)-1:0] i_sqi_sio_in
);
    localparam int SW = SQI_NUM * $bits(sqi_data_t);

    typedef enum logic [3:0] {
        ST_RSTQ, ST_GAP0, ST_EQIO, ST_GAP1, ST_IDLE,
        ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END
    } state_t;

    typedef struct packed {
        logic          cs_n;
        logic          oe;
        logic          idle;
        logic          wr_rdy;
        logic [SW-1:0] sio;
    } outs_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_wr;
    logic [15:0]     r_addr;
    logic            r_cs_n;
    logic            r_sck_en;
    logic            r_oe;
    logic [SW-1:0]   r_sio;
    logic            r_idle;
    logic            r_wr_rdy;
    logic            r_rd_vld;
    logic [SW-1:0]   r_rd_data;

    state_t          w_nstate;
    logic [3:0]      w_ncnt;
    logic            w_nwr;
    logic [15:0]     w_naddr;
    outs_t           w_outs;

    // Pin values presented while the FSM sits in state s at step c. RSTQ step 0 is
    // the post-reset cycle, so it keeps CS high like the reset values.
    function automatic outs_t decode(input state_t s, input logic [3:0] c,
                                     input logic wr, input logic [15:0] addr);
        outs_t      o;
        sqi_data_t  nib;
        logic [7:0] eqio;
        logic [23:0] baddr;
        logic [4:0] sh;
        o      = '0;
        o.cs_n = 1'b1;
        nib    = '0;
        eqio   = 8'h38;
        baddr  = {8'h00, addr};
        sh     = 5'd20 - {c[2:0], 2'b00};
        case (s)
            ST_RSTQ: begin
                if (c != 4'd0) begin
                    o.cs_n = 1'b0;
                    o.oe   = 1'b1;
                    o.sio  = '1;
                end
            end
            ST_EQIO: begin
                o.cs_n = 1'b0;
                o.oe   = 1'b1;
                o.sio  = {SQI_NUM{3'b000, eqio[3'd7 - c[2:0]]}};
            end
            ST_IDLE: o.idle = 1'b1;
            ST_CMD: begin
                o.cs_n = 1'b0;
                o.oe   = 1'b1;
                nib    = (c == 4'd0) ? 4'h0 : (wr ? 4'h2 : 4'h3);
                o.sio  = {SQI_NUM{nib}};
            end
            ST_ADDR: begin
                o.cs_n = 1'b0;
                o.oe   = 1'b1;
                nib    = sqi_data_t'(baddr >> sh);
                o.sio  = {SQI_NUM{nib}};
            end
            ST_DUMMY: o.cs_n = 1'b0;
            ST_DATA: begin
                o.cs_n   = 1'b0;
                o.oe     = wr;
                o.wr_rdy = wr;
            end
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt + 4'd1;
        w_nwr    = r_wr;
        w_naddr  = r_addr;
        case (r_state)
            ST_RSTQ:  if (r_cnt == 4'd2) begin w_nstate = ST_GAP0; w_ncnt = '0; end
            ST_GAP0:  begin w_nstate = ST_EQIO; w_ncnt = '0; end
            ST_EQIO:  if (r_cnt == 4'd7) begin w_nstate = ST_GAP1; w_ncnt = '0; end
            ST_GAP1:  begin w_nstate = ST_IDLE; w_ncnt = '0; end
            ST_IDLE: begin
                w_ncnt = '0;
                if (i_req) begin
                    w_nstate = ST_CMD;
                    w_nwr    = i_wr;
                    w_naddr  = i_addr;
                end
            end
            ST_CMD:   if (r_cnt == 4'd1) begin w_nstate = ST_ADDR; w_ncnt = '0; end
            ST_ADDR: begin
                if (r_cnt == 4'd5) begin
                    w_nstate = r_wr ? ST_DATA : ST_DUMMY;
                    w_ncnt   = '0;
                end
            end
            ST_DUMMY: if (r_cnt == 4'd1) begin w_nstate = ST_DATA; w_ncnt = '0; end
            ST_DATA: begin
                w_ncnt = '0;
                if (i_stop) w_nstate = ST_END;
            end
            ST_END:   begin w_nstate = ST_IDLE; w_ncnt = '0; end
            default:  begin w_nstate = ST_RSTQ; w_ncnt = '0; end
        endcase
        w_outs = decode(w_nstate, w_ncnt, w_nwr, w_naddr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_RSTQ;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_cs_n    <= 1'b1;
            r_sck_en  <= 1'b0;
            r_oe      <= 1'b0;
            r_sio     <= '0;
            r_idle    <= 1'b0;
            r_wr_rdy  <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_wr     <= w_nwr;
            r_addr   <= w_naddr;
            r_cs_n   <= w_outs.cs_n;
            r_sck_en <= !w_outs.cs_n;
            r_oe     <= w_outs.oe;
            r_sio    <= w_outs.sio;
            r_idle   <= w_outs.idle;
            r_wr_rdy <= w_outs.wr_rdy;
            // Read nibbles are captured at the end of every read DATA cycle.
            r_rd_vld <= (r_state == ST_DATA) && !r_wr;
            if ((r_state == ST_DATA) && !r_wr)
                r_rd_data <= i_sqi_sio_in;
        end
    end

    assign o_idle        = r_idle;
    assign o_rd_vld      = r_rd_vld;
    assign o_rd_data     = r_rd_data;
    assign o_wr_rdy      = r_wr_rdy;
    assign o_sqi_cs_n    = r_cs_n;
    assign o_sqi_sck_en  = r_sck_en;
    assign o_sqi_sio_oe  = r_oe;
    // Write data passes straight through so the core's nibble lands in the same cycle.
    assign o_sqi_sio_out = r_wr_rdy ? i_wr_data : r_sio;

endmodule
